decoder_3x8_pulse: RTL and testbench
====================================

# decoder_3x8_pulse

Registered 3-to-8 decoder with a valid/ready input, a 2-entry input buffer and a programmable output hold time. It accepts 3-bit binary codes, the format produced by the team's 8x3 encoder. Each accepted code drives the corresponding one-hot line of `out` for exactly `HOLD_CYCLES` clocks. It sits on the return side of the encoder path and drives one-hot select/strobe lines from a compact code stream.

## Interface
- `HOLD_CYCLES`, default 4: cycles each one-hot output is held; legal range 1..256.
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `in_code` is valid this cycle.
- `in_ready`  output  1  block can accept a code this cycle.
- `in_code`  input  3  binary code 0..7.
- `in_parity`  input  1  even-parity bit over `in_code`; used only with the parity macro.
- `out`  output  8  one-hot decoded line; `out[k]`=1 while code k is driven; all-zero when idle.
- `busy`  output  1  high while a code is being driven (state DRIVE).
- `done`  output  1  single-cycle pulse on the last hold cycle of each code.
- `err`  output  1  single-cycle pulse when a code is rejected for parity; tied 0 without the macro.

## Operation
- A code is accepted on any rising edge where `in_valid && in_ready`. Accepted codes are pushed into a 2-entry FIFO in arrival order.
- `in_ready` = (FIFO count < 2), driven from registered count only. A push and a pop in the same cycle are allowed when count is 1. No push when count is 2, even if a pop occurs that cycle.
- Hold counter `cnt`, width max(1, $clog2(HOLD_CYCLES)).
- States:
  - IDLE: `out`=0, `busy`=0. If the FIFO is non-empty: pop, `out` <= 1<<code, `cnt` <= HOLD_CYCLES-1, go to DRIVE.
  - DRIVE: `busy`=1. If `cnt`≠0: `cnt` decrements. If `cnt`==0: `done`=1 this cycle. Then, if the FIFO is non-empty, pop and load the next code with no gap cycle and stay in DRIVE. Otherwise `out` <= 0 and go to IDLE.
- `done` is combinational from (state==DRIVE && cnt==0), so it is coincident with the final cycle that `out` holds the code.
- In_code values are always 0..7; there are no illegal codes. Every code yields exactly one set bit.
- Reset mid-operation: the FIFO is flushed, the current code is abandoned with no `done`, and state returns to IDLE. Reset has priority over a simultaneous handshake, and that code is lost.

## Timing
- Reset values: `out`=8'h00, `busy`=0, `done`=0, `err`=0, `in_ready`=1, FIFO count=0, `cnt`=0, state IDLE.
- Latency: for a code accepted at edge N into an empty, idle block, `out` is one-hot from edge N+1 and holds through edge N+HOLD_CYCLES. `out` is 0 after edge N+1+HOLD_CYCLES if nothing else is queued.
- Throughput: one code per HOLD_CYCLES cycles. With `HOLD_CYCLES`=1, back-to-back codes produce a new one-hot value every cycle and `done` stays high continuously.
- The first code arriving at the same edge the FIFO is empty in IDLE is never driven at edge N. It always passes through the FIFO, giving a fixed latency of 1.
- When the FIFO is full, `in_ready` falls the cycle after the second push. It rises the cycle after a pop.

## Configuration
- `DECODER_PARITY_EN` defined:
  - At acceptance, `^{in_code,in_parity}` must equal 0.
  - On a mismatch, the handshake still completes (the code is consumed), but the code is not pushed into the FIFO. `err` pulses high for one cycle after the accepting edge.
  - FIFO state and `out` are unaffected.
- Not defined: `in_parity` is ignored, `err` is constant 0, and every accepted code is queued.

## Test plan
- Reset then idle, `HOLD_CYCLES`=4: hold `rst` for 2 cycles -> `out`=00, `busy`=0, `in_ready`=1, `done`=0.
- Single code 3'd5 accepted at edge N -> `out`=8'b0010_0000 on cycles N+1..N+4, `done` high only on cycle N+4, `out`=00 and `busy`=0 from N+5.
- Burst of 7, 0, 2, 4 with `in_valid` held high -> `in_ready` drops after two queued codes. Outputs are 80, 01, 04, 10, each for 4 cycles with no gap cycles, and `done` pulses 4 times.
- `HOLD_CYCLES`=1, codes 0..7 streamed every cycle -> `out` walks 01,02,...,80 on consecutive cycles and `done` stays high for 8 cycles.
- Reset asserted during the 2nd hold cycle of code 3 with 1 entry queued -> `out`=00 the next cycle, no `done`, queued code discarded, `in_ready`=1.
- `DECODER_PARITY_EN` defined: send code 3'd6 with `in_parity`=1 (bad) -> `err` pulses once and `out` stays 00. Then send 3'd6 with `in_parity`=0 -> `out`=8'b0100_0000 for HOLD_CYCLES.

Source files
------------

// File: rtl/decoder_3x8_pulse.sv
// Registered 3-to-8 decoder: valid/ready input, 2-entry FIFO, each code held HOLD_CYCLES clocks.
// Optional parity check on accepted codes enabled by defining DECODER_PARITY_EN.
module decoder_3x8_pulse #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_code,
   input  logic       in_parity,
   output logic [7:0] out,
   output logic       busy,
   output logic       done,
   output logic       err
);
   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_out;
   logic [2:0]    r_mem [2];
   logic          r_wptr;
   logic          r_rptr;
   logic [1:0]    r_count;

   logic w_accept;
   logic w_par_ok;
   logic w_push;
   logic w_pop;

   assign in_ready = (r_count < 2'd2);
   assign w_accept = in_valid && in_ready;

`ifdef DECODER_PARITY_EN
   logic r_err;
   assign w_par_ok = ~^{in_code, in_parity};

   always_ff @(posedge clk) begin
      if (rst) r_err <= 1'b0;
      else     r_err <= w_accept && !w_par_ok;
   end
   assign err = r_err;
`else
   // in_parity has no effect in this build
   assign w_par_ok = in_parity | 1'b1;
   assign err      = 1'b0;
`endif

   assign w_push = w_accept && w_par_ok;
   // Pop whenever the FSM is ready for a new code: idle, or on the last hold cycle
   assign w_pop  = (r_count != 2'd0) && ((r_state == IDLE) || (r_cnt == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= in_code;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         r_count <= r_count + 2'(w_push) - 2'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_out   <= 8'h00;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_count != 2'd0) begin
                  r_out   <= 8'd1 << r_mem[r_rptr];
                  r_cnt   <= LOAD;
                  r_state <= DRIVE;
               end
            end
            DRIVE: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end else if (r_count != 2'd0) begin
                  r_out <= 8'd1 << r_mem[r_rptr];
                  r_cnt <= LOAD;
               end else begin
                  r_out   <= 8'h00;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out  = r_out;
   assign busy = (r_state == DRIVE);
   assign done = (r_state == DRIVE) && (r_cnt == '0);
endmodule

// File: tb/tb_decoder_3x8_pulse.sv
// Bench for decoder_3x8_pulse: directed scenarios plus random traffic against a queue-based model.
// Parity scenarios follow DECODER_PARITY_EN.
module tb_decoder_3x8_pulse;
   localparam int H4 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4, v4, p4, rdy4, busy4, done4, err4;
   logic [2:0] c4;
   logic [7:0] out4;
   logic       rst1, v1, p1, rdy1, busy1, done1, err1;
   logic [2:0] c1;
   logic [7:0] out1;

   int total = 0;
   int bad   = 0;

   decoder_3x8_pulse #(.HOLD_CYCLES(H4)) u_dut4 (
      .clk(clk), .rst(rst4), .in_valid(v4), .in_ready(rdy4), .in_code(c4), .in_parity(p4),
      .out(out4), .busy(busy4), .done(done4), .err(err4));

   decoder_3x8_pulse #(.HOLD_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst1), .in_valid(v1), .in_ready(rdy1), .in_code(c1), .in_parity(p1),
      .out(out1), .busy(busy1), .done(done1), .err(err1));

   // Reference model for the HOLD=4 instance: queue of pending codes, current code, cycles left
   int q[$];
   int cur = -1;
   int rem = 0;
   bit m_err = 1'b0;
   bit m_acc, m_ok;

   always @(posedge clk) begin
      if (rst4) begin
         q.delete(); cur = -1; rem = 0; m_err = 1'b0;
      end else begin
         m_acc = v4 && (q.size() < 2);
`ifdef DECODER_PARITY_EN
         m_ok = ((^{c4, p4}) == 1'b0);
`else
         m_ok = 1'b1;
`endif
         if (cur < 0) begin
            if (q.size() > 0) begin cur = q.pop_front(); rem = H4; end
         end else if (rem == 1) begin
            if (q.size() > 0) begin cur = q.pop_front(); rem = H4; end
            else cur = -1;
         end else rem--;
         if (m_acc && m_ok) q.push_back(int'(c4));
         m_err = m_acc && !m_ok;
      end
   end

   task automatic drain4();
      v4 = 1'b0; rst4 = 1'b0;
      repeat (16) @(negedge clk);
   endtask

   task automatic test_reset();
      rst4 = 1'b1; rst1 = 1'b1; v4 = 1'b0; v1 = 1'b0;
      c4 = 3'd0; c1 = 3'd0; p4 = 1'b0; p1 = 1'b0;
      repeat (2) @(negedge clk);
      rst4 = 1'b0; rst1 = 1'b0;
      total++; if (out4 !== 8'h00) begin bad++; $display("FAIL reset_out got=%h exp=00", out4); end
      total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy4); end
      total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", rdy4); end
      total++; if (done4 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done4); end
      total++; if (err4 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err4); end
      total++; if (out1 !== 8'h00 || rdy1 !== 1'b1 || done1 !== 1'b0) begin
         bad++; $display("FAIL reset_h1 out=%h rdy=%b done=%b exp 00/1/0", out1, rdy1, done1);
      end
   endtask

   task automatic test_single();
      drain4();
      v4 = 1'b1; c4 = 3'd5; p4 = 1'b0;
      @(negedge clk);
      v4 = 1'b0;
      total++; if (out4 !== 8'h00) begin bad++; $display("FAIL single_lat got=%h exp=00", out4); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         total++; if (out4 !== 8'h20) begin bad++; $display("FAIL single_out k=%0d got=%h exp=20", k, out4); end
         total++; if (done4 !== (k == 4)) begin bad++; $display("FAIL single_done k=%0d got=%b exp=%b", k, done4, k == 4); end
      end
      @(negedge clk);
      total++; if (out4 !== 8'h00 || busy4 !== 1'b0) begin
         bad++; $display("FAIL single_end out=%h busy=%b exp 00/0", out4, busy4);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] codes [4];
      logic [7:0] expv  [4];
      logic [7:0] obs   [40];
      int idx, f, ndone;
      bit rdy_prev, saw_low, ok;
      codes[0] = 3'd7; codes[1] = 3'd0; codes[2] = 3'd2; codes[3] = 3'd4;
      expv[0] = 8'h80; expv[1] = 8'h01; expv[2] = 8'h04; expv[3] = 8'h10;
      drain4();
      idx = 0; ndone = 0; saw_low = 1'b0;
      v4 = 1'b1; c4 = codes[0]; p4 = ^codes[0]; rdy_prev = rdy4;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         obs[j] = out4;
         if (done4 === 1'b1) ndone++;
         if (rdy4 === 1'b0) saw_low = 1'b1;
         if (v4 && rdy_prev) idx++;
         if (idx < 4) begin c4 = codes[idx]; p4 = ^codes[idx]; end
         else v4 = 1'b0;
         rdy_prev = rdy4;
      end
      f = -1;
      for (int j = 39; j >= 0; j--) if (obs[j] !== 8'h00) f = j;
      total++;
      if (f < 0 || f + 16 >= 40) begin
         bad++; $display("FAIL burst_start first_nonzero=%0d exp within window", f);
      end else begin
         ok = 1'b1;
         for (int i = 0; i < 16; i++) if (obs[f+i] !== expv[i/4]) ok = 1'b0;
         if (obs[f+16] !== 8'h00) ok = 1'b0;
         if (!ok) begin
            bad++; $display("FAIL burst_seq got=%h %h %h %h %h exp=80 01 04 10 00",
                            obs[f], obs[f+4], obs[f+8], obs[f+12], obs[f+16]);
         end
      end
      total++; if (ndone != 4) begin bad++; $display("FAIL burst_done got=%0d exp=4", ndone); end
      total++; if (!saw_low) begin bad++; $display("FAIL burst_ready got=never_low exp=low_once"); end
   endtask

   task automatic test_hold1();
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (j >= 2) begin
            total++; if (out1 !== (8'd1 << (j-2))) begin bad++; $display("FAIL h1_out j=%0d got=%h exp=%h", j, out1, 8'd1 << (j-2)); end
            total++; if (done1 !== 1'b1) begin bad++; $display("FAIL h1_done j=%0d got=%b exp=1", j, done1); end
         end
         total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL h1_ready j=%0d got=%b exp=1", j, rdy1); end
         if (j < 8) begin v1 = 1'b1; c1 = 3'(j); p1 = ^c1; end
         else v1 = 1'b0;
      end
      @(negedge clk);
      total++; if (out1 !== 8'h00 || done1 !== 1'b0 || busy1 !== 1'b0) begin
         bad++; $display("FAIL h1_end out=%h done=%b busy=%b exp 00/0/0", out1, done1, busy1);
      end
   endtask

   task automatic test_reset_mid();
      int nd;
      drain4();
      v4 = 1'b1; c4 = 3'd3; p4 = 1'b0;
      @(negedge clk);
      c4 = 3'd1; p4 = 1'b1;
      @(negedge clk);
      v4 = 1'b0;
      total++; if (out4 !== 8'h08) begin bad++; $display("FAIL rmid_hold1 got=%h exp=08", out4); end
      @(negedge clk);
      total++; if (out4 !== 8'h08 || done4 !== 1'b0) begin bad++; $display("FAIL rmid_hold2 out=%h done=%b exp 08/0", out4, done4); end
      rst4 = 1'b1;
      @(negedge clk);
      rst4 = 1'b0;
      total++; if (out4 !== 8'h00 || busy4 !== 1'b0 || rdy4 !== 1'b1) begin
         bad++; $display("FAIL rmid_after out=%h busy=%b rdy=%b exp 00/0/1", out4, busy4, rdy4);
      end
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         if (out4 !== 8'h00 || done4 !== 1'b0) nd++;
      end
      total++; if (nd != 0) begin bad++; $display("FAIL rmid_flush active_cycles=%0d exp=0", nd); end
   endtask

   task automatic test_parity();
      drain4();
      v4 = 1'b1; c4 = 3'd6; p4 = 1'b1;
      @(negedge clk);
      v4 = 1'b0; p4 = 1'b0;
`ifdef DECODER_PARITY_EN
      total++; if (err4 !== 1'b1) begin bad++; $display("FAIL par_err got=%b exp=1", err4); end
      @(negedge clk);
      total++; if (err4 !== 1'b0) begin bad++; $display("FAIL par_err_pulse got=%b exp=0", err4); end
      repeat (4) @(negedge clk);
      total++; if (out4 !== 8'h00 || busy4 !== 1'b0) begin bad++; $display("FAIL par_dropped out=%h busy=%b exp 00/0", out4, busy4); end
      v4 = 1'b1; c4 = 3'd6; p4 = 1'b0;
      @(negedge clk);
      v4 = 1'b0;
`endif
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         total++; if (out4 !== 8'h40 || err4 !== 1'b0) begin
            bad++; $display("FAIL par_out k=%0d out=%h err=%b exp 40/0", k, out4, err4);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] e_out;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         e_out = (cur < 0) ? 8'h00 : (8'd1 << cur);
         total++; if (out4 !== e_out) begin bad++; $display("FAIL rnd_out n=%0d got=%h exp=%h", n, out4, e_out); end
         total++; if (busy4 !== (cur >= 0)) begin bad++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy4, cur >= 0); end
         total++; if (done4 !== (cur >= 0 && rem == 1)) begin bad++; $display("FAIL rnd_done n=%0d got=%b exp=%b", n, done4, cur >= 0 && rem == 1); end
         total++; if (rdy4 !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, rdy4, q.size() < 2); end
         total++; if (err4 !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err4, m_err); end
         rst4 = ($urandom_range(0, 99) < 2);
         v4   = ($urandom_range(0, 99) < 60);
         c4   = 3'($urandom_range(0, 7));
         p4   = (^c4) ^ ($urandom_range(0, 99) < 20);
      end
      rst4 = 1'b0; v4 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_hold1();
      test_reset_mid();
      test_parity();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
